// File: rtl/mult_arb_pkg.sv
// ----------------------------------------------------------------------------
// mult_arb_pkg
// Shared constants and types for the round-robin multiplier arbiter slice.
//   OPW       : operand width (8)
//   PRW       : product width (16)
//   MAX_NREQ  : largest supported requester count (8)
//   state_t   : sequencer FSM states
//   next_idx  : round-robin successor of a requester index
// ----------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int OPW      = 8;
    localparam int PRW      = 16;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Successor of idx in a ring of n requesters (n-1 wraps to 0).
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_8x8.sv
// ----------------------------------------------------------------------------
// mult_8x8
// Unsigned 8x8 array multiplier. Partial products are reduced with a chain of
// 3:2 carry-save compressors to a sum/carry pair, which a Kogge-Stone prefix
// adder resolves into the 16-bit product.
// Build option: MULT_PIPE_EN inserts one register between the compression
// stage and the final adder (adds a clk port, one cycle of latency).
//   clk   : clock (MULT_PIPE_EN builds only)
//   a, b  : 8-bit unsigned operands
//   p     : 16-bit unsigned product
// ----------------------------------------------------------------------------
module mult_8x8
    import mult_arb_pkg::*;
(
`ifdef MULT_PIPE_EN
    input  logic           clk,
`endif
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PRW-1:0] p
);

    logic [PRW-1:0] cs_s, cs_c;   // compressor outputs
    logic [PRW-1:0] ks_s, ks_c;   // final-adder inputs

    // Carry-save reduction of the partial-product array. The carry shifted
    // out of bit 15 is always zero because the product fits in 16 bits.
    always_comb begin
        logic [PRW-1:0] pp, ns, nc;
        cs_s = '0;
        cs_c = '0;
        pp   = '0;
        ns   = '0;
        nc   = '0;
        for (int i = 0; i < OPW; i++) begin
            pp   = PRW'(a & {OPW{b[i]}}) << i;
            ns   = cs_s ^ cs_c ^ pp;
            nc   = ((cs_s & cs_c) | (cs_s & pp) | (cs_c & pp)) << 1;
            cs_s = ns;
            cs_c = nc;
        end
    end

`ifdef MULT_PIPE_EN
    // NOTE: pure datapath pipeline register, no reset: it is always written
    // one cycle before the sequencer reads the product.
    always_ff @(posedge clk) begin
        ks_s <= cs_s;
        ks_c <= cs_c;
    end
`else
    assign ks_s = cs_s;
    assign ks_c = cs_c;
`endif

    // Kogge-Stone prefix over bits 0..PRW-2; g[k] ends as the carry out of
    // bit k, which is the carry into bit k+1.
    always_comb begin
        logic [PRW-2:0] g, pr, g_n, p_n;
        g   = ks_s[PRW-2:0] & ks_c[PRW-2:0];
        pr  = ks_s[PRW-2:0] ^ ks_c[PRW-2:0];
        g_n = g;
        p_n = pr;
        for (int d = 1; d < PRW - 1; d = d * 2) begin
            g_n = g;
            p_n = pr;
            for (int k = d; k < PRW - 1; k++) begin
                g_n[k] = g[k] | (pr[k] & g[k-d]);
                p_n[k] = pr[k] & pr[k-d];
            end
            g  = g_n;
            pr = p_n;
        end
        p = (ks_s ^ ks_c) ^ {g, 1'b0};
    end

endmodule

// File: rtl/mult_rr_arbiter_pick.sv
// ----------------------------------------------------------------------------
// mult_rr_pick
// Combinational round-robin picker: finds the first asserted valid bit
// starting at ptr and searching upward with wrap NREQ-1 -> 0.
//   valid [NREQ] : request vector
//   ptr   [IDW]  : highest-priority index (always < NREQ)
//   grant [NREQ] : one-hot grant, all zero when nothing is valid
//   idx   [IDW]  : index of the granted requester (0 when none)
//   any          : at least one request is valid
// ----------------------------------------------------------------------------
module mult_rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the search loop, otherwise
        // the paths that find nothing would infer latches.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mult_rr_arbiter
// Round-robin arbiter and sequencer sharing one 8x8 multiplier between NREQ
// requesters. One operation in flight: IDLE grants/accepts, EXEC (and EXEC2
// when MULT_PIPE_EN is defined) computes, RESP holds the product until the
// consumer takes it. Synchronous active-low reset.
// Build option: MULT_PIPE_EN (pipelined multiplier, latency 3 instead of 2).
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/req_ready     : per-requester operand handshake (ready one-hot)
//   req_a, req_b            : packed operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready     : product handshake
//   rsp_p, rsp_id           : product and originating requester index
// ----------------------------------------------------------------------------
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [PRW-1:0]     rsp_p,
    output logic [IDW-1:0]     rsp_id
);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   rid;
    logic [OPW-1:0]   op_a, op_b;
    logic [OPW-1:0]   sel_a, sel_b;
    logic [PRW-1:0]   prod;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    mult_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Operand slice of the picked requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_a = req_a[OPW*i +: OPW];
                sel_b = req_b[OPW*i +: OPW];
            end
        end
    end

    // Grants are only offered in IDLE and never while reset is asserted.
    assign req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
    assign rsp_id    = rid;

    mult_8x8 u_mul (
`ifdef MULT_PIPE_EN
        .clk (clk),
`endif
        .a   (op_a),
        .b   (op_b),
        .p   (prod)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            rid       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_p     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        rid   <= pick_idx;
                        ptr   <= IDW'(next_idx(int'(pick_idx), NREQ));
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef MULT_PIPE_EN
                    state     <= ST_EXEC2;
`else
                    rsp_p     <= prod;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
`endif
                end
                ST_EXEC2: begin
                    rsp_p     <= prod;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mult_rr_arbiter
// Directed + randomized bench for mult_rr_arbiter (NREQ=4). The reference
// model tracks only the round-robin priority index and computes products
// with plain integer multiplication.
// ----------------------------------------------------------------------------
module tb_mult_rr_arbiter;

    localparam int NREQ = 4;
`ifdef MULT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int PER = LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_p;
    logic [1:0]  rsp_id;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;            // model: index with highest priority
    logic [7:0] ta [4];
    logic [7:0] tb [4];

    mult_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = ta[i];
            req_b[8*i +: 8] = tb[i];
        end
    endtask

    // First valid requester at or after the priority index, wrapping.
    function automatic int model_pick(input logic [3:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return 0;
    endfunction

    // One full transaction: grant, compute (random request noise while busy),
    // hold RESP for 'hold' cycles with rsp_ready low, then handshake.
    task automatic op(input logic [3:0] mask, input int hold);
        int g;
        int cyc;
        logic [31:0] ep;
        load_ops();
        rsp_ready = 1'b0;
        req_valid = mask;
        #1;
        g  = model_pick(mask);
        ep = 32'(ta[g]) * 32'(tb[g]);
        chk("grant", 32'(req_ready), 32'(1) << g);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        step();
        mptr = (g + 1) % NREQ;
        req_valid = 4'($urandom);
        #1;
        cyc = 1;
        while (!rsp_valid && cyc < 12) begin
            chk("busy_ready", 32'(req_ready), 0);
            step();
            req_valid = 4'($urandom);
            #1;
            cyc++;
        end
        chk("latency", cyc, LAT);
        chk("rsp_p", 32'(rsp_p), ep);
        chk("rsp_id", 32'(rsp_id), g);
        chk("resp_ready", 32'(req_ready), 0);
        for (int h = 0; h < hold; h++) begin
            step();
            req_valid = 4'($urandom);
            #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_p", 32'(rsp_p), ep);
            chk("hold_id", 32'(rsp_id), g);
            chk("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = 8'(i + 3);
            tb[i] = 8'(2 * i + 5);
        end

        // Reset state, with a request pending to show no grant during reset.
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        step();
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_p", 32'(rsp_p), 0);
        chk("rst_id", 32'(rsp_id), 0);
        rst_n     = 1'b1;
        req_valid = '0;
        mptr      = 0;
        step();
        #1;

        // Idle with no requests: nothing granted.
        for (int i = 0; i < 3; i++) begin
            chk("idle_none", 32'(req_ready), 0);
            step();
            #1;
        end

        // Single request from requester 2.
        ta[2] = 8'h0C; tb[2] = 8'h0D;
        op(4'b0100, 0);

        // Arithmetic corners.
        ta[0] = 8'h00; tb[0] = 8'hFF; op(4'b0001, 0);
        ta[3] = 8'hFF; tb[3] = 8'hFF; op(4'b1000, 0);
        ta[1] = 8'h80; tb[1] = 8'h02; op(4'b0010, 1);

        // Backpressure: RESP held 5 cycles.
        op(4'b1111, 5);

        // Reset one cycle after accept: no response, pointer back to 0.
        load_ops();
        req_valid = 4'b0100;
        step();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 0);
        step();
        #1;
        chk("mid_rst_ready2", 32'(req_ready), 0);
        chk("mid_rst_p", 32'(rsp_p), 0);
        rst_n     = 1'b1;
        req_valid = '0;
        mptr      = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("mid_rst_no_rsp", 32'(rsp_valid), 0);
        end
        op(4'b1010, 0);

        // Fairness from a fresh reset: all valid, rsp_ready high.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mptr  = 0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = 8'($urandom);
            tb[i] = 8'($urandom);
        end
        load_ops();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 5 * PER; c++) begin
            #1;
            g = (c / PER) % NREQ;
            chk("fair_ready", 32'(req_ready), (c % PER == 0) ? (32'(1) << g) : 0);
            chk("fair_rsp_valid", 32'(rsp_valid), (c % PER == LAT) ? 1 : 0);
            if (c % PER == LAT) begin
                chk("fair_id", 32'(rsp_id), g);
                chk("fair_p", 32'(rsp_p), 32'(ta[g]) * 32'(tb[g]));
            end
            step();
        end
        rsp_ready = 1'b0;
        req_valid = '0;
        mptr      = 1;
        #1;

        // Randomized transactions.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                ta[i] = 8'($urandom);
                tb[i] = 8'($urandom);
            end
            op(4'($urandom_range(1, 15)), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational 8x8 unsigned array multiplier (16-bit product, Kogge-Stone final adder) between NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake, registers the operands into the multiplier, captures the product and returns it with the requester's ID over a second valid/ready handshake. It sits between the requesting datapath blocks and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters (1..8)
- IDW, $clog2(NREQ) (min 1), width of RSP_ID
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous, active-low reset
- REQ_VALID  in  NREQ  per-requester operand valid
- REQ_READY  out  NREQ  per-requester accept; at most one bit high
- REQ_A  in  8*NREQ  multiplicand, requester i at [8i+7:8i]
- REQ_B  in  8*NREQ  multiplier, requester i at [8i+7:8i]
- RSP_VALID  out  1  product valid
- RSP_READY  in  1  consumer accepts product
- RSP_P  out  16  unsigned product A*B
- RSP_ID  out  IDW  index of requester that issued the operands

## Operation
- Single outstanding operation; FSM states IDLE, EXEC, (EXEC2 under MULT_PIPE_EN), RESP.
- IDLE: REQ_READY is combinational, one-hot to the first requester with REQ_VALID high, searching from PTR upward with wrap NREQ-1 -> 0. No valid -> REQ_READY all zero, stay IDLE.
- Accept (REQ_VALID[i] & REQ_READY[i]): latch REQ_A/REQ_B slice i into operand registers, latch i into ID register, PTR <= (i+1) mod NREQ, go EXEC.
- EXEC: multiplier driven from operand registers; product registered into RSP_P at end of cycle; go RESP (or EXEC2).
- RESP: RSP_VALID=1; RSP_P, RSP_ID stable until RSP_READY. On RSP_READY, go IDLE. No new request accepted in EXEC/EXEC2/RESP (REQ_READY all zero).
- Arithmetic: full 16-bit unsigned product, no truncation; 0xFF*0xFF = 0xFE01.
- Requester may drop REQ_VALID before being granted; no grant, no penalty. Priority pointer only moves on accept.
- NREQ=1: pointer stays 0, RSP_ID=0.

## Timing
- Reset (RST_N low at rising edge): state IDLE, PTR=0, REQ_READY=0 during reset, RSP_VALID=0, RSP_P=0, RSP_ID=0, operand regs 0. Reset mid-operation discards the in-flight op; no response is issued.
- Latency: accept edge at cycle 0 -> RSP_VALID high in cycle 2 (cycle 3 with MULT_PIPE_EN).
- RSP_READY held high: throughput one product per 3 cycles (4 with MULT_PIPE_EN); IDLE lasts one cycle minimum after response handshake.
- RSP_READY low: RESP held indefinitely, outputs frozen.
- REQ_READY depends only on state, PTR and REQ_VALID; never on RSP_READY.

## Configuration
- MULT_PIPE_EN defined: multiplier split at partial-product compression / final adder boundary with one pipeline register; FSM adds EXEC2; latency 3, throughput 1/4.
- Undefined: multiplier fully combinational between operand register and RSP_P register; latency 2, throughput 1/3.

## Structure
- Package mult_arb_pkg: operand width (8), product width (16), FSM state enum, max NREQ.
- Sub-module mult_rr_pick: combinational round-robin picker (REQ_VALID, PTR -> one-hot grant, index). Multiplier instantiated as the existing 8x8 multiplier module.

## Test plan
- Single request: REQ_VALID[2]=1, A=0x0C, B=0x0D -> REQ_READY[2] in same cycle, RSP_VALID at cycle 2, RSP_P=0x009C, RSP_ID=2.
- Corners: 0x00*0xFF -> 0x0000; 0xFF*0xFF -> 0xFE01; 0x80*0x02 -> 0x0100.
- Fairness: all 4 valid continuously, RSP_READY=1 -> grant order 0,1,2,3,0 (PTR wraps), one grant every 3 cycles.
- Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_VALID, RSP_P, RSP_ID constant, REQ_READY all zero; release -> IDLE next cycle.
- Reset mid-EXEC: RST_N low one cycle after accept -> RSP_VALID never rises, PTR=0, next grant goes to lowest-index valid requester.
- MULT_PIPE_EN build: repeat first scenario -> RSP_VALID at cycle 3, same RSP_P.
